// File: rtl/des_key_schedule_seq.sv
// Iterative DES key scheduler: one 48-bit subkey per clock for a bundle of
// NUM_KEYS keys, served through a registered random-access read port.
module des_key_schedule_seq #(
  parameter int NUM_KEYS     = 3,
  parameter int CHECK_PARITY = 1,
  parameter int KSEL_W       = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [64*NUM_KEYS-1:0]   key_in,
  output logic                     busy,
  output logic                     done,
  output logic                     keys_valid,
  output logic                     parity_err,
  input  logic [KSEL_W-1:0]        rd_key_sel,
  input  logic [3:0]               rd_round,
  input  logic                     rd_decrypt,
  output logic [47:0]              rd_subkey,
  output logic [1:0]               state_dbg
);

  // Handshake: start is sampled on a rising edge only in IDLE; busy rises on
  // the following cycle and done pulses for exactly one cycle at the end.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_FIN} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  state_t                    state;
  logic [64*NUM_KEYS-1:0]    key_r;
  logic [KSEL_W-1:0]         kidx;
  logic [3:0]                round;
  logic [27:0]               c_q, d_q;
  logic [NUM_KEYS*16*48-1:0] store;

  logic [63:0] cur_key;
  logic [55:0] cd_load;
  logic        par_bad;
  logic        one_step;
  logic [27:0] c_rot, d_rot;
  logic [55:0] cd_rot;
  logic [47:0] subkey;
  logic        rd_oob;
  int          rd_off;
  int          wr_off;

  assign state_dbg = state;

  // DES numbers bits 1..64 from the MSB, hence the 64-n / 56-n mappings.
  always_comb begin
    cur_key = key_r[(NUM_KEYS - 1 - int'(kidx)) * 64 +: 64];
    cd_load = '0;
    for (int i = 0; i < 56; i++) cd_load[55-i] = cur_key[64-PC1[i]];
    par_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (~^cur_key[b*8 +: 8]) par_bad = 1'b1;
    end
    if (CHECK_PARITY == 0) par_bad = 1'b0;

    one_step = (round == 4'd0) || (round == 4'd1) || (round == 4'd8) || (round == 4'd15);
    c_rot    = one_step ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
    d_rot    = one_step ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
    cd_rot   = {c_rot, d_rot};
    subkey   = '0;
    for (int j = 0; j < 48; j++) subkey[47-j] = cd_rot[56-PC2[j]];

    wr_off = int'(kidx) * 16 + int'(round);
    rd_oob = ({1'b0, rd_key_sel} >= (KSEL_W+1)'(NUM_KEYS));
    rd_off = 0;
    if (!rd_oob)
      rd_off = int'(rd_key_sel) * 16 + int'(rd_decrypt ? (4'd15 - rd_round) : rd_round);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      key_r      <= '0;
      kidx       <= '0;
      round      <= '0;
      c_q        <= '0;
      d_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      parity_err <= 1'b0;
      rd_subkey  <= '0;
    end else begin
      done      <= 1'b0;
      rd_subkey <= rd_oob ? 48'h0 : store[rd_off*48 +: 48];
      case (state)
        S_IDLE: begin
          if (start) begin
            key_r      <= key_in;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            parity_err <= 1'b0;
            kidx       <= '0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          {c_q, d_q} <= cd_load;
          if (par_bad) parity_err <= 1'b1;
          round      <= '0;
          state      <= S_ROUND;
        end
        S_ROUND: begin
          c_q <= c_rot;
          d_q <= d_rot;
          if (round == 4'd15) begin
            if (kidx == KSEL_W'(NUM_KEYS - 1)) begin
              busy       <= 1'b0;
              done       <= 1'b1;
              keys_valid <= 1'b1;
              state      <= S_FIN;
            end else begin
              kidx  <= kidx + 1'b1;
              state <= S_LOAD;
            end
          end else begin
            round <= round + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Subkey store needs no reset: its contents are only meaningful under keys_valid.
  always_ff @(posedge clk) begin
    if (state == S_ROUND) store[wr_off*48 +: 48] <= subkey;
  end

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Directed bench for des_key_schedule_seq: a 1-key and a 3-key instance,
// checked against the classic worked-example subkeys and a reference model.
module tb_des_key_schedule_seq;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_C = 64'hFEDCBA9876543210;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Worked-example subkeys K1..K16 for KEY_A.
  logic [47:0] exp_k [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          start1 = 1'b0;
  logic [63:0]   key1 = '0;
  logic          busy1, done1, kv1, perr1;
  logic [1:0]    sel1 = '0;
  logic [3:0]    rnd1 = '0;
  logic          dec1 = 1'b0;
  logic [47:0]   sk1;
  logic [1:0]    st1;

  logic          start3 = 1'b0;
  logic [191:0]  key3 = '0;
  logic          busy3, done3, kv3, perr3;
  logic [1:0]    sel3 = '0;
  logic [3:0]    rnd3 = '0;
  logic          dec3 = 1'b0;
  logic [47:0]   sk3;
  logic [1:0]    st3;

  int total = 0;
  int bad = 0;
  logic [47:0] exp_q [$];

  always #5 clk = ~clk;

  des_key_schedule_seq #(.NUM_KEYS(1), .CHECK_PARITY(1), .KSEL_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key_in(key1),
    .busy(busy1), .done(done1), .keys_valid(kv1), .parity_err(perr1),
    .rd_key_sel(sel1), .rd_round(rnd1), .rd_decrypt(dec1),
    .rd_subkey(sk1), .state_dbg(st1));

  des_key_schedule_seq #(.NUM_KEYS(3), .CHECK_PARITY(1), .KSEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .key_in(key3),
    .busy(busy3), .done(done3), .keys_valid(kv3), .parity_err(perr3),
    .rd_key_sel(sel3), .rd_round(rnd3), .rd_decrypt(dec3),
    .rd_subkey(sk3), .state_dbg(st3));

  function automatic logic [47:0] model_subkey(input logic [63:0] k, input int r);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] s;
    int sh;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    sh = 0;
    for (int j = 0; j <= r; j++) sh += (j == 0 || j == 1 || j == 8 || j == 15) ? 1 : 2;
    for (int t = 0; t < sh; t++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int j = 0; j < 48; j++) s[47-j] = cd[56-PC2_T[j]];
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_run1(input logic [63:0] k);
    @(negedge clk);
    key1 = k; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic start_run3(input logic [191:0] k);
    @(negedge clk);
    key3 = k; start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; returns edges until done.
  task automatic wait_done1(output int edges);
    edges = 0;
    while (!done1 && edges < 200) begin
      @(posedge clk); edges++; @(negedge clk);
    end
  endtask

  task automatic wait_done3(output int edges);
    edges = 0;
    while (!done3 && edges < 200) begin
      @(posedge clk); edges++; @(negedge clk);
    end
  endtask

  task automatic read1(input logic [3:0] r, input logic dec, output logic [47:0] v);
    rnd1 = r; dec1 = dec; sel1 = 2'd0;
    @(posedge clk); @(negedge clk);
    v = sk1;
  endtask

  task automatic read3(input logic [1:0] s, input logic [3:0] r, input logic dec,
                       output logic [47:0] v);
    sel3 = s; rnd3 = r; dec3 = dec;
    @(posedge clk); @(negedge clk);
    v = sk3;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy1, done1, kv1, perr1, sk1, st1} !== 54'h0) begin
      bad++; $display("FAIL reset_dut1 got=%h exp=0", {busy1, done1, kv1, perr1, sk1, st1});
    end
    total++;
    if ({busy3, done3, kv3, perr3, sk3, st3} !== 54'h0) begin
      bad++; $display("FAIL reset_dut3 got=%h exp=0", {busy3, done3, kv3, perr3, sk3, st3});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int e;
    logic [47:0] v;
    start_run1(KEY_A);
    total++;
    if (busy1 !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy1); end
    wait_done1(e);
    total++;
    if (e != 17) begin bad++; $display("FAIL single_latency got=cycle %0d exp=cycle 18", e + 1); end
    total++;
    if ({busy1, kv1, perr1} !== 3'b010) begin
      bad++; $display("FAIL single_flags got=%b exp=010", {busy1, kv1, perr1});
    end
    read1(4'd0, 1'b0, v);
    total++;
    if (v !== 48'h1B02EFFC7072) begin bad++; $display("FAIL single_r0 got=%h exp=1b02effc7072", v); end
    read1(4'd15, 1'b0, v);
    total++;
    if (v !== 48'hCB3D8B0E17F5) begin bad++; $display("FAIL single_r15 got=%h exp=cb3d8b0e17f5", v); end
  endtask

  task automatic test_decrypt_sweep;
    logic [47:0] v, x;
    for (int dec = 0; dec < 2; dec++) begin
      for (int r = 0; r < 16; r++) begin
        exp_q.push_back(dec != 0 ? exp_k[15-r] : exp_k[r]);
        read1(4'(r), dec[0], v);
        x = exp_q.pop_front();
        total++;
        if (v !== x) begin
          bad++; $display("FAIL sweep dec=%0d r=%0d got=%h exp=%h", dec, r, v, x);
        end
      end
    end
  endtask

  task automatic test_three_keys;
    int e;
    logic [47:0] v, x;
    logic [63:0] ks [3];
    ks[0] = KEY_A; ks[1] = KEY_B; ks[2] = KEY_C;
    start_run3({KEY_A, KEY_B, KEY_C});
    key3 = '1;
    wait_done3(e);
    total++;
    if (e != 51) begin bad++; $display("FAIL three_latency got=cycle %0d exp=cycle 52", e + 1); end
    total++;
    if ({kv3, perr3} !== 2'b10) begin bad++; $display("FAIL three_flags got=%b exp=10", {kv3, perr3}); end
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 16; r++) begin
        exp_q.push_back(k == 0 ? exp_k[r] : model_subkey(ks[k], r));
        read3(2'(k), 4'(r), 1'b0, v);
        x = exp_q.pop_front();
        total++;
        if (v !== x) begin bad++; $display("FAIL three k=%0d r=%0d got=%h exp=%h", k, r, v, x); end
      end
    end
    read3(2'd3, 4'd5, 1'b0, v);
    total++;
    if (v !== 48'h0) begin bad++; $display("FAIL three_sel3 got=%h exp=0", v); end
    read3(2'd2, 4'd2, 1'b1, v);
    x = model_subkey(KEY_C, 13);
    total++;
    if (v !== x) begin bad++; $display("FAIL three_dec got=%h exp=%h", v, x); end
  endtask

  task automatic test_parity;
    int e;
    logic [47:0] v;
    start_run1(64'h133457799BBCDFF0);
    wait_done1(e);
    total++;
    if (perr1 !== 1'b1) begin bad++; $display("FAIL parity_set got=%b exp=1", perr1); end
    for (int r = 0; r < 16; r += 5) begin
      read1(4'(r), 1'b0, v);
      total++;
      if (v !== exp_k[r]) begin bad++; $display("FAIL parity_sk r=%0d got=%h exp=%h", r, v, exp_k[r]); end
    end
    start_run1(KEY_A);
    total++;
    if ({perr1, kv1} !== 2'b00) begin bad++; $display("FAIL parity_clear got=%b exp=00", {perr1, kv1}); end
    wait_done1(e);
    total++;
    if ({perr1, kv1} !== 2'b01) begin bad++; $display("FAIL parity_done got=%b exp=01", {perr1, kv1}); end
  endtask

  task automatic test_busy_ignore;
    int n, ndone, done_at;
    logic busy_drop;
    logic [47:0] v, x;
    start_run3({KEY_A, KEY_B, KEY_C});
    n = 0; ndone = 0; done_at = -1; busy_drop = 1'b0;
    while (n < 70) begin
      start3 = (n == 4 || n == 16);
      key3 = {KEY_C, KEY_C, KEY_C};
      @(posedge clk); n++; @(negedge clk);
      if (done3) begin ndone++; done_at = n; end
      if (n < 51 && busy3 !== 1'b1) busy_drop = 1'b1;
    end
    start3 = 1'b0;
    total++;
    if (ndone != 1 || done_at != 51) begin
      bad++; $display("FAIL busy_done count=%0d at=%0d exp count=1 at=51", ndone, done_at);
    end
    total++;
    if (busy_drop !== 1'b0) begin bad++; $display("FAIL busy_high got=drop exp=steady"); end
    for (int r = 0; r < 16; r += 3) begin
      read3(2'd0, 4'(r), 1'b0, v);
      total++;
      if (v !== exp_k[r]) begin bad++; $display("FAIL busy_k0 r=%0d got=%h exp=%h", r, v, exp_k[r]); end
    end
    read3(2'd1, 4'd7, 1'b0, v);
    x = model_subkey(KEY_B, 7);
    total++;
    if (v !== x) begin bad++; $display("FAIL busy_k1 got=%h exp=%h", v, x); end
  endtask

  task automatic test_reset_mid_run;
    int e;
    logic [47:0] v, x;
    start_run3({KEY_C, KEY_A, KEY_B});
    repeat (29) begin @(posedge clk); @(negedge clk); end
    total++;
    if (busy3 !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy3); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy3, done3, kv3, perr3, sk3, st3} !== 54'h0) begin
      bad++; $display("FAIL midrst_async got=%h exp=0", {busy3, done3, kv3, perr3, sk3, st3});
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_run3({KEY_C, KEY_A, KEY_B});
    wait_done3(e);
    total++;
    if (e != 51 || kv3 !== 1'b1) begin
      bad++; $display("FAIL midrst_latency got=cycle %0d kv=%b exp=cycle 52 kv=1", e + 1, kv3);
    end
    read3(2'd1, 4'd9, 1'b0, v);
    total++;
    if (v !== exp_k[9]) begin bad++; $display("FAIL midrst_k1 got=%h exp=%h", v, exp_k[9]); end
    read3(2'd0, 4'd0, 1'b0, v);
    x = model_subkey(KEY_C, 0);
    total++;
    if (v !== x) begin bad++; $display("FAIL midrst_k0 got=%h exp=%h", v, x); end
  endtask

  task automatic test_back_to_back;
    int e;
    logic [47:0] v;
    start_run3({KEY_B, KEY_B, KEY_A});
    total++;
    if ({busy3, kv3} !== 2'b10) begin bad++; $display("FAIL b2b_kv_clear got=%b exp=10", {busy3, kv3}); end
    wait_done3(e);
    @(posedge clk); @(negedge clk);
    start_run3({KEY_A, KEY_A, KEY_A});
    wait_done3(e);
    total++;
    if (e != 51) begin bad++; $display("FAIL b2b_latency got=cycle %0d exp=cycle 52", e + 1); end
    read3(2'd2, 4'd3, 1'b1, v);
    total++;
    if (v !== exp_k[12]) begin bad++; $display("FAIL b2b_read got=%h exp=%h", v, exp_k[12]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_decrypt_sweep();
    test_three_keys();
    test_parity();
    test_busy_ignore();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_key_schedule_seq.md
Name: des_key_schedule_seq

Overview:
Iterative, parametrised DES key scheduler for single-DES and 3DES engines. It accepts a bundle of NUM_KEYS 64-bit keys and computes one 48-bit round subkey per clock into an internal subkey store. Subkeys are then served through a registered random-access read port, in encrypt or decrypt order per read. It replaces the fully unrolled schedule with a smaller, time-multiplexed one and adds a start/done handshake, multi-key support and a parity check.

Parameters:
NUM_KEYS, 3, number of 64-bit keys in the bundle; legal values 1..3
CHECK_PARITY, 1, 1 enables the odd-parity check on every key byte; 0 forces parity_err to 0
KSEL_W, 2, width of rd_key_sel; must satisfy 2**KSEL_W >= NUM_KEYS

Ports:
clk  in  1  clock, all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to schedule key_in; honoured only while busy=0
key_in  in  64*NUM_KEYS  key bundle; key 0 in bits [64*NUM_KEYS-1 -: 64], key 1 next; bit 63 of each key is DES bit 1
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when all subkeys are written
keys_valid  out  1  high while the store holds a complete schedule
parity_err  out  1  sticky: some key byte had even parity; cleared by the next accepted start
rd_key_sel  in  KSEL_W  key index for the read port
rd_round  in  4  round index 0..15 (round 1..16)
rd_decrypt  in  1  1 = return the subkey for round 15-rd_round
rd_subkey  out  48  registered read data

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE. busy, done, keys_valid, parity_err and rd_subkey go to 0. Round counter and key counter go to 0. Store contents are don't-care, because keys_valid=0.
- Key bundle capture: on an accepted start, key_in is registered whole. Later key_in changes do not affect the run.
- FSM states:
  - IDLE: start=1 captures key_in, sets busy=1, clears keys_valid and parity_err, sets kidx=0, then goes to LOAD.
  - LOAD: applies PC-1 (56 bits, standard DES table) to key kidx into the C/D registers. Evaluates parity of the 8 bytes of key kidx and ORs any even-parity byte into parity_err (when CHECK_PARITY=1). Sets round=0 and goes to ROUND.
  - ROUND: rotates C and D left, each 28 bits, by 1 for rounds 0,1,8,15 and by 2 otherwise. Writes PC-2 of the rotated C/D into store[kidx][round], in the same cycle as the rotation. At round=15: if kidx=NUM_KEYS-1, go to FIN; else kidx++ and go to LOAD. Otherwise round++.
  - FIN: done=1 for one cycle, busy=0, keys_valid=1, then go to IDLE.
- Latency: each key takes 17 cycles (1 LOAD + 16 ROUND). With start sampled at edge 0, done is high in cycle 17*NUM_KEYS+1; NUM_KEYS=3 gives done in cycle 52.
- start while busy=1 is ignored. It is neither queued nor does it corrupt the run.
- start in the FIN cycle is ignored. start is accepted from the following IDLE cycle onward.
- Read port:
  - rd_subkey <= store[rd_key_sel][rd_decrypt ? 15-rd_round : rd_round], with 1-cycle latency.
  - The port is always enabled. Reads while keys_valid=0 return undefined data, and the bench must not check them.
  - rd_key_sel >= NUM_KEYS returns 48'h0.
- Reset mid-run: everything aborts. keys_valid stays 0 until a full new run completes.
- A new start after keys_valid=1 clears keys_valid immediately, so no partial schedule is ever flagged valid.
- Storage is NUM_KEYS*16 x 48 flops. Subkey bit 47 is PC-2 output bit 1.

Test Plan:
1. NUM_KEYS=1, key 64'h133457799BBCDFF1, start -> done in cycle 18, parity_err=0; read round 0 -> 48'h1B02EFFC7072; read round 15 -> 48'hCB3D8B0E17F5.
2. Same key, rd_decrypt=1, rd_round=0 -> 48'hCB3D8B0E17F5; rd_round=15 -> 48'h1B02EFFC7072. Sweep all 32 combinations against the software model.
3. NUM_KEYS=3, keys {133457799BBCDFF1, 0123456789ABCDEF, FEDCBA9876543210} -> done in cycle 52. All 48 subkeys match the model, and rd_key_sel=3 returns 0.
4. Flip bit 0 of key 133457799BBCDFF1 (so 133457799BBCDFF0) -> parity_err=1 at done and subkeys unchanged (parity bits are dropped by PC-1). The next start with a valid key clears parity_err.
5. start pulsed at cycles 5 and 17 during a run -> single done at the original time. busy stays continuously high, and the results are those of the first key.
6. rst_n low at cycle 30 of a 3-key run -> all outputs 0 asynchronously. A fresh start after release yields correct results with done at the full latency.
